// File: rtl/mc_rfr_exec_if.sv
// Refresh executor bus: request/ack handshake, grant, timing fields and SDRAM command pins.
// The master side is the refresh generator and controller; the slave side is mc_rfr_exec.
interface mc_rfr_exec_if #(
   parameter int TW = 4
);
   logic          rfr_req;
   logic          rfr_ack;
   logic [7:0]    cs_need_rfr;
   logic          mc_gnt;
   logic          rfr_busy;
   logic [TW-1:0] trp;
   logic [TW-1:0] trfc;
   logic [7:0]    cs_n;
   logic          ras_n;
   logic          cas_n;
   logic          we_n;
   logic          a10;

   modport master (
      output rfr_req, cs_need_rfr, mc_gnt, trp, trfc,
      input  rfr_ack, rfr_busy, cs_n, ras_n, cas_n, we_n, a10
   );

   modport slave (
      input  rfr_req, cs_need_rfr, mc_gnt, trp, trfc,
      output rfr_ack, rfr_busy, cs_n, ras_n, cas_n, we_n, a10
   );
endinterface

// File: rtl/mc_rfr_exec.sv
// Refresh executor: waits for bus grant, then issues PRECHARGE-ALL and AUTO-REFRESH with tRP/tRFC.
// Define MC_RFR_DOUBLE_EN to issue two AUTO-REFRESH commands per request.
module mc_rfr_exec #(
   parameter int TW = 4
) (
   input  logic               clk,
   input  logic               rst,
   mc_rfr_exec_if.slave       bus
);

   typedef enum logic [3:0] {
      IDLE,
      WAIT_GNT,
      PRE,
      TRP,
      REF,
      TRFC,
`ifdef MC_RFR_DOUBLE_EN
      REF2,
      TRFC2,
`endif
      ACK
   } state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [7:0]    cs_mask;
   logic          ack_q;
   logic          busy_q;
   logic [7:0]    cs_n_q;
   logic          ras_n_q;
   logic          cas_n_q;
   logic          we_n_q;
   logic          a10_q;

   // A programmed delay of zero behaves as one cycle, so the load value saturates at 0.
   logic [TW-1:0] trp_m1;
   logic [TW-1:0] trfc_m1;
   assign trp_m1  = (bus.trp  == '0) ? '0 : bus.trp  - TW'(1);
   assign trfc_m1 = (bus.trfc == '0) ? '0 : bus.trfc - TW'(1);

   // Command pins are set on the transition into a command state, so every output is a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         timer   <= '0;
         cs_mask <= 8'h00;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         cs_n_q  <= 8'hff;
         ras_n_q <= 1'b1;
         cas_n_q <= 1'b1;
         we_n_q  <= 1'b1;
         a10_q   <= 1'b0;
      end else begin
         ack_q   <= 1'b0;
         cs_n_q  <= 8'hff;
         ras_n_q <= 1'b1;
         cas_n_q <= 1'b1;
         we_n_q  <= 1'b1;
         a10_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.rfr_req) begin
                  state  <= WAIT_GNT;
                  busy_q <= 1'b1;
               end
            end
            WAIT_GNT: begin
               if (!bus.rfr_req) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else if (bus.mc_gnt) begin
                  cs_mask <= bus.cs_need_rfr;
                  if (bus.cs_need_rfr == 8'h00) begin
                     state <= ACK;
                     ack_q <= 1'b1;
                  end else begin
                     state   <= PRE;
                     cs_n_q  <= ~bus.cs_need_rfr;
                     ras_n_q <= 1'b0;
                     we_n_q  <= 1'b0;
                     a10_q   <= 1'b1;
                  end
               end
            end
            PRE: begin
               timer <= trp_m1;
               state <= TRP;
            end
            TRP: begin
               if (timer != '0) begin
                  timer <= timer - TW'(1);
               end else begin
                  state   <= REF;
                  cs_n_q  <= ~cs_mask;
                  ras_n_q <= 1'b0;
                  cas_n_q <= 1'b0;
               end
            end
            REF: begin
               timer <= trfc_m1;
               state <= TRFC;
            end
            TRFC: begin
               if (timer != '0) begin
                  timer <= timer - TW'(1);
               end else begin
`ifdef MC_RFR_DOUBLE_EN
                  state   <= REF2;
                  cs_n_q  <= ~cs_mask;
                  ras_n_q <= 1'b0;
                  cas_n_q <= 1'b0;
`else
                  state <= ACK;
                  ack_q <= 1'b1;
`endif
               end
            end
`ifdef MC_RFR_DOUBLE_EN
            REF2: begin
               timer <= trfc_m1;
               state <= TRFC2;
            end
            TRFC2: begin
               if (timer != '0) begin
                  timer <= timer - TW'(1);
               end else begin
                  state <= ACK;
                  ack_q <= 1'b1;
               end
            end
`endif
            ACK: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rfr_ack  = ack_q;
   assign bus.rfr_busy = busy_q;
   assign bus.cs_n     = cs_n_q;
   assign bus.ras_n    = ras_n_q;
   assign bus.cas_n    = cas_n_q;
   assign bus.we_n     = we_n_q;
   assign bus.a10      = a10_q;

endmodule

// File: tb/tb_mc_rfr_exec.sv
// Testbench for mc_rfr_exec: per-cycle trace checking against a transaction-level model,
// directed vector table, randomized transactions, and hand-written reset/abort sequences.
module tb_mc_rfr_exec;
   localparam int TW = 4;

`ifdef MC_RFR_DOUBLE_EN
   localparam int NREF = 2;
`else
   localparam int NREF = 1;
`endif

   // Output word layout: {ack, busy, cs_n[7:0], ras_n, cas_n, we_n, a10}
   localparam logic [12:0] IDLE_O = {1'b0, 1'b0, 8'hff, 4'b1110};
   localparam logic [12:0] NOP_O  = {1'b0, 1'b1, 8'hff, 4'b1110};
   localparam logic [12:0] ACK_O  = {1'b1, 1'b1, 8'hff, 4'b1110};

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [12:0] exp_q[$];

   always #5 clk = ~clk;

   mc_rfr_exec_if #(.TW(TW)) bus ();
   mc_rfr_exec #(.TW(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic logic [12:0] outs();
      return {bus.rfr_ack, bus.rfr_busy, bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n, bus.a10};
   endfunction

   task automatic checkOutput(input string name, input logic [12:0] got, input logic [12:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%h exp=%h (ack,busy,cs_n,ras,cas,we,a10)", name, got, exp);
      end
   endtask

   task automatic checkInt(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Expected per-cycle trace of one request, built from the command sequence it should produce.
   task automatic buildTrace(input int d, input logic [7:0] m, input int tp, input int tf);
      int ntp = (tp == 0) ? 1 : tp;
      int ntf = (tf == 0) ? 1 : tf;
      exp_q.delete();
      exp_q.push_back(IDLE_O);
      for (int i = 0; i <= d; i++) exp_q.push_back(NOP_O);
      if (m != 8'h00) begin
         exp_q.push_back({1'b0, 1'b1, ~m, 4'b0101});
         for (int i = 0; i < ntp; i++) exp_q.push_back(NOP_O);
         for (int r = 0; r < NREF; r++) begin
            exp_q.push_back({1'b0, 1'b1, ~m, 4'b0010});
            for (int i = 0; i < ntf; i++) exp_q.push_back(NOP_O);
         end
      end
      exp_q.push_back(ACK_O);
      exp_q.push_back(IDLE_O);
   endtask

   task automatic applyStimulus(input string tag, input int d, input logic [7:0] m,
                                input int tp, input int tf, input bit wild,
                                output int pre_cyc, output int ack_cyc, output int nref);
      int n;
      buildTrace(d, m, tp, tf);
      n = exp_q.size();
      bus.trp  = tp[TW-1:0];
      bus.trfc = tf[TW-1:0];
      pre_cyc = -1;
      ack_cyc = -1;
      nref    = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         checkOutput($sformatf("%s_cyc%0d", tag, k), outs(), exp_q[k]);
         if (bus.rfr_ack && ack_cyc < 0) ack_cyc = k;
         if (!bus.ras_n && bus.cas_n && !bus.we_n && pre_cyc < 0) pre_cyc = k;
         if (!bus.ras_n && !bus.cas_n && bus.we_n) nref++;
         if (k == 0) bus.rfr_req = 1'b1;
         else if (k == n - 2) bus.rfr_req = 1'b0;
         if (k <= d) bus.mc_gnt = 1'b0;
         else if (k == d + 1 || !wild) bus.mc_gnt = 1'b1;
         else bus.mc_gnt = 1'($urandom_range(0, 1));
         if (k == d + 1 || !wild) bus.cs_need_rfr = m;
         else bus.cs_need_rfr = 8'($urandom);
      end
   endtask

   typedef struct {
      int         d;
      logic [7:0] m;
      int         tp;
      int         tf;
      int         exp_pre;
      int         exp_ack;
      int         exp_ref;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int pre_c, ack_c, nr;
      int d, tp, tf;
      logic [7:0] m;

`ifdef MC_RFR_DOUBLE_EN
      vecs[0] = '{0,  8'h05, 2,  4,  2,  15, 2};
      vecs[1] = '{20, 8'hff, 2,  4,  22, 35, 2};
      vecs[2] = '{0,  8'h00, 3,  3,  -1, 2,  0};
      vecs[3] = '{0,  8'h01, 0,  0,  2,  8,  2};
      vecs[4] = '{1,  8'h80, 15, 15, 3,  51, 2};
      vecs[5] = '{3,  8'h3c, 1,  3,  5,  15, 2};
`else
      vecs[0] = '{0,  8'h05, 2,  4,  2,  10, 1};
      vecs[1] = '{20, 8'hff, 2,  4,  22, 30, 1};
      vecs[2] = '{0,  8'h00, 3,  3,  -1, 2,  0};
      vecs[3] = '{0,  8'h01, 0,  0,  2,  6,  1};
      vecs[4] = '{1,  8'h80, 15, 15, 3,  35, 1};
      vecs[5] = '{3,  8'h3c, 1,  3,  5,  11, 1};
`endif

      rst = 1'b1;
      bus.rfr_req = 1'b0;
      bus.mc_gnt = 1'b0;
      bus.cs_need_rfr = 8'h00;
      bus.trp = '0;
      bus.trfc = '0;
      #1;
      checkOutput("reset_async", outs(), IDLE_O);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].d, vecs[i].m, vecs[i].tp, vecs[i].tf,
                       1'b0, pre_c, ack_c, nr);
         checkInt($sformatf("vec%0d_pre_cycle", i), pre_c, vecs[i].exp_pre);
         checkInt($sformatf("vec%0d_ack_cycle", i), ack_c, vecs[i].exp_ack);
         checkInt($sformatf("vec%0d_ref_count", i), nr, vecs[i].exp_ref);
      end

      for (int i = 0; i < 40; i++) begin
         d  = $urandom_range(0, 5);
         tp = $urandom_range(0, 15);
         tf = $urandom_range(0, 15);
         m  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         applyStimulus($sformatf("rnd%0d", i), d, m, tp, tf, 1'b1, pre_c, ack_c, nr);
         checkInt($sformatf("rnd%0d_ref_count", i), nr, (m == 8'h00) ? 0 : NREF);
      end

      // Reset asserted while the precharge delay is counting down.
      @(negedge clk);
      bus.trp = 4'd8;
      bus.trfc = 4'd2;
      bus.cs_need_rfr = 8'hff;
      bus.mc_gnt = 1'b1;
      bus.rfr_req = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("mid_trp_busy", outs(), NOP_O);
      rst = 1'b1;
      #1;
      checkOutput("mid_trp_reset_async", outs(), IDLE_O);
      bus.rfr_req = 1'b0;
      @(negedge clk);
      checkOutput("mid_trp_reset_held", outs(), IDLE_O);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         checkOutput($sformatf("post_reset_idle%0d", k), outs(), IDLE_O);
      end

      // Request withdrawn while waiting for grant: back to idle without an ack.
      bus.mc_gnt = 1'b0;
      bus.rfr_req = 1'b1;
      @(negedge clk);
      checkOutput("drop_wait_gnt", outs(), NOP_O);
      bus.rfr_req = 1'b0;
      @(negedge clk);
      checkOutput("drop_idle0", outs(), IDLE_O);
      bus.mc_gnt = 1'b1;
      @(negedge clk);
      checkOutput("drop_idle1", outs(), IDLE_O);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
